// File: rtl/reg_scoreboard.sv
// reg_scoreboard -- register file with per-register pending-write scoreboard.
//
// Tracks in-flight writes per destination register with a small counter.
// Issue is stalled while any used source has a pending write, or while the
// destination counter is saturated. Register 0 is hard-wired to zero.
//
// Optional feature macro: REG_SCOREBOARD_BYPASS_EN
//   When defined, a writeback is forwarded to matching source ports in the
//   same cycle, and a source whose only pending write is that writeback is
//   not treated as hazarded.
//
// Ports:
//   CLOCK_50    in   rising-edge clock
//   RSTN_N      in   asynchronous active-low reset
//   rs_addr     in   NRD*AW  source indices, port i at [i*AW +: AW]
//   rs_used     in   NRD     port i source is needed by the issuing instr
//   rs_data     out  NRD*XLEN combinational source operand values
//   issue_valid in   issue request
//   issue_rd    in   AW      destination index of the issuing instruction
//   issue_ready out  issue may be accepted (independent of issue_valid)
//   wb_valid    in   writeback strobe
//   wb_rd       in   AW      writeback destination
//   wb_data     in   XLEN    writeback value
//   idle        out  no pending writes anywhere
//   wb_err      out  sticky: writeback arrived with no pending write
module reg_scoreboard #(
  parameter  int XLEN    = 32,
  parameter  int NREG    = 32,
  parameter  int NRD     = 2,
  parameter  int MAXPEND = 3,
  localparam int AW      = $clog2(NREG),
  localparam int CW      = $clog2(MAXPEND + 1)
) (
  input  logic                 CLOCK_50,
  input  logic                 RSTN_N,
  input  logic [NRD*AW-1:0]    rs_addr,
  input  logic [NRD-1:0]       rs_used,
  output logic [NRD*XLEN-1:0]  rs_data,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_rd,
  output logic                 issue_ready,
  input  logic                 wb_valid,
  input  logic [AW-1:0]        wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  output logic                 idle,
  output logic                 wb_err
);

  localparam logic [CW-1:0] PEND_MAX = CW'(MAXPEND);
  localparam logic [CW-1:0] PEND_ONE = CW'(1);

  logic [XLEN-1:0] regs [NREG];
  logic [CW-1:0]   pend [NREG];
  logic [NRD-1:0]  port_hzd;
  logic [NREG-1:0] iss_hit;
  logic [NREG-1:0] wb_hit;
  logic            iss_acc;
  logic            wb_orphan;

  // Counter update. A same-cycle issue and writeback cancel out; a
  // writeback to an empty counter leaves it at zero (flagged separately).
  function automatic logic [CW-1:0] pend_next(input logic [CW-1:0] cur,
                                              input logic inc,
                                              input logic dec);
    if (inc && !dec)
      return cur + PEND_ONE;
    else if (dec && !inc && cur != '0)
      return cur - PEND_ONE;
    else
      return cur;
  endfunction

  // Source read ports: operand mux and hazard detection
  for (genvar i = 0; i < NRD; i++) begin : g_port
    logic [AW-1:0] a;
    assign a = rs_addr[i*AW +: AW];
`ifdef REG_SCOREBOARD_BYPASS_EN
    logic byp;
    assign byp = wb_valid && (wb_rd == a) && (a != '0);
    assign rs_data[i*XLEN +: XLEN] = byp ? wb_data : regs[a];
    // The in-flight writeback satisfies the last outstanding write.
    assign port_hzd[i] = rs_used[i] && (a != '0) && (pend[a] != '0) &&
                         !(byp && (pend[a] == PEND_ONE));
`else
    assign rs_data[i*XLEN +: XLEN] = regs[a];
    assign port_hzd[i] = rs_used[i] && (a != '0) && (pend[a] != '0);
`endif
  end

  assign issue_ready = ~|port_hzd &&
                       ((issue_rd == '0) || (pend[issue_rd] < PEND_MAX));
  assign iss_acc     = issue_valid && issue_ready;

  // Per-register decode; register 0 never matches so it stays zero.
  for (genvar r = 0; r < NREG; r++) begin : g_hit
    if (r == 0) begin : g_zero
      assign iss_hit[r] = 1'b0;
      assign wb_hit[r]  = 1'b0;
    end else begin : g_live
      assign iss_hit[r] = iss_acc  && (issue_rd == AW'(r));
      assign wb_hit[r]  = wb_valid && (wb_rd    == AW'(r));
    end
  end

  assign wb_orphan = wb_valid && (wb_rd != '0) && (pend[wb_rd] == '0) &&
                     !(iss_acc && (issue_rd == wb_rd));

  always_comb begin
    idle = 1'b1;
    for (int r = 0; r < NREG; r++)
      if (pend[r] != '0) idle = 1'b0;
  end

  // Register array, counters and error flag update on the clock edge
  always_ff @(posedge CLOCK_50 or negedge RSTN_N) begin
    if (!RSTN_N) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
        pend[r] <= '0;
      end
      wb_err <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (wb_hit[r]) regs[r] <= wb_data;
        pend[r] <= pend_next(pend[r], iss_hit[r], wb_hit[r]);
      end
      if (wb_orphan) wb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic                CLOCK_50;
  logic                RSTN_N;
  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD-1:0]      rs_used;
  logic [NRD*XLEN-1:0] rs_data;
  logic                issue_valid;
  logic [AW-1:0]       issue_rd;
  logic                issue_ready;
  logic                wb_valid;
  logic [AW-1:0]       wb_rd;
  logic [XLEN-1:0]     wb_data;
  logic                idle;
  logic                wb_err;

  int n_checks = 0;
  int n_fail   = 0;

  reg_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .MAXPEND(3)) dut (
    .CLOCK_50   (CLOCK_50),
    .RSTN_N     (RSTN_N),
    .rs_addr    (rs_addr),
    .rs_used    (rs_used),
    .rs_data    (rs_data),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .issue_ready(issue_ready),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .idle       (idle),
    .wb_err     (wb_err)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Return 1 ns after the next rising edge, a safe point to drive inputs.
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic set_src0(input logic [AW-1:0] a, input logic used);
    rs_addr[0 +: AW] = a;
    rs_used[0]       = used;
  endtask

  initial begin
    RSTN_N = 1'b0; rs_addr = '0; rs_used = '0;
    issue_valid = 1'b0; issue_rd = '0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    repeat (2) tick();
    RSTN_N = 1'b1;
    tick();

    // Reset state: every register reads zero on both ports
    for (int r = 0; r < NREG; r++) begin
      rs_addr = {AW'(r), AW'(r)};
      #1;
      check($sformatf("rst_r%0d_p0", r), rs_data[0 +: XLEN], 32'h0);
      check($sformatf("rst_r%0d_p1", r), rs_data[XLEN +: XLEN], 32'h0);
    end
    check("rst_idle", {31'd0, idle}, 32'd1);
    check("rst_ready", {31'd0, issue_ready}, 32'd1);
    check("rst_wb_err", {31'd0, wb_err}, 32'd0);

    // RAW hazard on r1 resolved by writeback of 2
    tick();
    issue_valid = 1'b1; issue_rd = 5'd1;
    #1 check("raw_ready_first", {31'd0, issue_ready}, 32'd1);
    tick();
    issue_valid = 1'b0; issue_rd = 5'd2;
    set_src0(5'd1, 1'b1);
    #1 check("raw_stall", {31'd0, issue_ready}, 32'd0);
    check("raw_not_idle", {31'd0, idle}, 32'd0);
    tick();
    #1 check("raw_stall_2", {31'd0, issue_ready}, 32'd0);
    wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'd2;
    #1;
`ifdef REG_SCOREBOARD_BYPASS_EN
    check("raw_wbcyc_ready", {31'd0, issue_ready}, 32'd1);
    check("raw_wbcyc_data", rs_data[0 +: XLEN], 32'd2);
`else
    check("raw_wbcyc_ready", {31'd0, issue_ready}, 32'd0);
    check("raw_wbcyc_data", rs_data[0 +: XLEN], 32'd0);
`endif
    tick();
    wb_valid = 1'b0;
    #1 check("raw_after_ready", {31'd0, issue_ready}, 32'd1);
    check("raw_after_data", rs_data[0 +: XLEN], 32'd2);
    check("raw_after_idle", {31'd0, idle}, 32'd1);

    // Two back-to-back issues to r1, drained by two writebacks
    set_src0(5'd1, 1'b0);
    issue_valid = 1'b1; issue_rd = 5'd1;
    tick();
    tick();
    issue_valid = 1'b0;
    #1 check("b2b_pend2", 32'(dut.pend[1]), 32'd2);
    check("b2b_busy2", {31'd0, idle}, 32'd0);
    wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'd2;
    tick();
    wb_data = 32'd3;
    #1 check("b2b_pend1", 32'(dut.pend[1]), 32'd1);
    check("b2b_busy1", {31'd0, idle}, 32'd0);
    tick();
    wb_valid = 1'b0;
    #1 check("b2b_pend0", 32'(dut.pend[1]), 32'd0);
    check("b2b_idle", {31'd0, idle}, 32'd1);
    check("b2b_r1", rs_data[0 +: XLEN], 32'd3);

    // Saturate r5 at three pending writes
    issue_valid = 1'b1; issue_rd = 5'd5;
    repeat (3) tick();
    #1 check("sat_ready_r5", {31'd0, issue_ready}, 32'd0);
    tick();
    issue_valid = 1'b0;
    #1 check("sat_pend_r5", 32'(dut.pend[5]), 32'd3);
    issue_rd = 5'd6;
    #1 check("sat_ready_r6", {31'd0, issue_ready}, 32'd1);
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h55;
    repeat (3) tick();
    wb_valid = 1'b0;
    #1 check("sat_drain_idle", {31'd0, idle}, 32'd1);
    check("sat_drain_err", {31'd0, wb_err}, 32'd0);

    // Same-cycle issue and writeback to r3 leaves count unchanged
    issue_valid = 1'b1; issue_rd = 5'd3;
    tick();
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h33;
    #1 check("same_ready", {31'd0, issue_ready}, 32'd1);
    tick();
    issue_valid = 1'b0; wb_valid = 1'b0;
    set_src0(5'd3, 1'b0);
    #1 check("same_pend3", 32'(dut.pend[3]), 32'd1);
    check("same_r3", rs_data[0 +: XLEN], 32'h33);
    wb_valid = 1'b1; wb_data = 32'h34;
    tick();
    wb_valid = 1'b0;
    #1 check("same_drain_idle", {31'd0, idle}, 32'd1);

    // Register 0: issue and writeback are both discarded
    issue_valid = 1'b1; issue_rd = 5'd0;
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF;
    #1 check("r0_ready", {31'd0, issue_ready}, 32'd1);
    tick();
    issue_valid = 1'b0; wb_valid = 1'b0;
    set_src0(5'd0, 1'b0);
    #1 check("r0_pend", 32'(dut.pend[0]), 32'd0);
    check("r0_idle", {31'd0, idle}, 32'd1);
    check("r0_data", rs_data[0 +: XLEN], 32'd0);
    check("r0_err", {31'd0, wb_err}, 32'd0);

    // Orphan writeback to r7 writes data and sets the sticky flag
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEAD;
    tick();
    wb_valid = 1'b0;
    set_src0(5'd7, 1'b0);
    #1 check("orph_r7", rs_data[0 +: XLEN], 32'hDEAD);
    check("orph_err", {31'd0, wb_err}, 32'd1);
    check("orph_pend7", 32'(dut.pend[7]), 32'd0);
    repeat (3) tick();
    check("orph_err_sticky", {31'd0, wb_err}, 32'd1);

    // Reset mid-operation discards pending state
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    issue_valid = 1'b0;
    #1 check("mid_busy", {31'd0, idle}, 32'd0);
    #2 RSTN_N = 1'b0;
    #1 check("mid_rst_err", {31'd0, wb_err}, 32'd0);
    check("mid_rst_idle", {31'd0, idle}, 32'd1);
    check("mid_rst_r7", rs_data[0 +: XLEN], 32'd0);
    tick();
    RSTN_N = 1'b1;
    tick();
    wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h99;
    tick();
    wb_valid = 1'b0;
    set_src0(5'd9, 1'b0);
    #1 check("mid_post_err", {31'd0, wb_err}, 32'd1);
    check("mid_post_r9", rs_data[0 +: XLEN], 32'h99);
    check("mid_post_idle", {31'd0, idle}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width per register.
REQ-002 SHALL have parameter NREG, default 32, register count; AW = $clog2(NREG).
REQ-003 SHALL have parameter NRD, default 2, number of source read ports.
REQ-004 SHALL have parameter MAXPEND, default 3, max in-flight writes per register; CW = $clog2(MAXPEND+1).
REQ-005 SHALL use one clock; reset is asynchronous and active-low: CLOCK_50 in 1, rising-edge clock.
REQ-006 SHALL have RSTN_N in 1, asynchronous active-low reset.
REQ-007 SHALL have rs_addr in NRD*AW, source register indices, port i at bits [i*AW +: AW].
REQ-008 SHALL have rs_used in NRD, port i source is needed by the issuing instruction.
REQ-009 SHALL have rs_data out NRD*XLEN, combinational source operand values.
REQ-010 SHALL have issue_valid in 1, issue_rd in AW, issue_ready out 1: instruction issue handshake with destination index.
REQ-011 SHALL have wb_valid in 1, wb_rd in AW, wb_data in XLEN: writeback port.
REQ-012 SHALL have idle out 1 (no pending writes) and wb_err out 1 (sticky underflow flag).

Function
REQ-013 SHALL hold NREG registers of XLEN bits; register 0 SHALL always read 0, and writes and pending counts to it SHALL be discarded.
REQ-014 SHALL keep per-register counter pend[r] of CW bits.
REQ-015 SHALL accept an issue on a rising edge when issue_valid && issue_ready; pend[issue_rd] += 1.
REQ-016 SHALL, on wb_valid, write wb_data to wb_rd at the edge and decrement pend[wb_rd].
REQ-017 SHALL leave pend unchanged when an accepted issue and a writeback target the same register in one cycle.
REQ-018 SHALL, on wb_valid with pend[wb_rd]==0 and no same-cycle issue to wb_rd, still write data, hold pend at 0, and set wb_err until reset.
REQ-019 SHALL flag port i as hazarded when rs_used[i], rs_addr[i]!=0 and pend[rs_addr[i]]!=0, except as relaxed by REQ-027.
REQ-020 SHALL drive issue_ready = no port hazarded && (issue_rd==0 || pend[issue_rd] < MAXPEND); issue_ready SHALL NOT depend on issue_valid.
REQ-021 SHALL drive rs_data[i] from the register array, with zero latency.
REQ-022 SHALL drive idle high iff all pend[r]==0.

Reset
REQ-023 SHALL, while RSTN_N low, clear all registers and all pend to 0 and clear wb_err.
REQ-024 SHALL after reset present issue_ready=1 (when all pend are 0 and issue_rd valid), idle=1, wb_err=0 and rs_data all 0.
REQ-025 SHALL discard in-flight state on reset asserted mid-operation; writebacks after release to pend==0 registers set wb_err.

Configuration
REQ-026 SHALL compile a same-cycle writeback bypass only when macro REG_SCOREBOARD_BYPASS_EN is defined.
REQ-027 SHALL, with REG_SCOREBOARD_BYPASS_EN, drive rs_data[i]=wb_data when wb_valid && wb_rd==rs_addr[i]!=0, and not hazard port i if pend[rs_addr[i]]==1 and that writeback is present.
REQ-028 SHALL, without REG_SCOREBOARD_BYPASS_EN, show written values only from the cycle after the writeback edge, with REQ-019 unrelaxed.

Verification
REQ-029 SHALL check: reset, then read r0..r31 -> all 0, idle=1, issue_ready=1.
REQ-030 SHALL check: issue rd=1, next cycle read rs_addr0=1 used -> issue_ready=0 until wb r1=2; with BYPASS_EN ready=1 and rs_data0=2 in the wb cycle, without it ready=1 and rs_data0=2 one cycle later.
REQ-031 SHALL check: two back-to-back issues to r1 (MAXPEND=3) then wb r1=2, wb r1=3 -> pend 2,1,0; idle only after second wb; r1 reads 3.
REQ-032 SHALL check: three issues to r5 -> issue_ready=0 for a fourth issue_rd=5 while issue_rd=6 gives ready=1.
REQ-033 SHALL check: wb r7=0xDEAD with pend[7]=0 -> r7 reads 0xDEAD, wb_err=1 and stays 1 until RSTN_N low.
REQ-034 SHALL check: issue and wb to r3 in same cycle with pend[3]=1 -> pend[3] stays 1; rd=0 issue/wb -> no pend change, r0 reads 0.
